// File: rtl/key_buffer_ctrl.sv
// Frame-level keypoint buffer sequencer: gate front-end keypoints in, drain them to the matcher.
// Latency: keypoint->write strobe 0 cycles; frame_end->first out_valid 1 cycle; last pop->frame_done 1 cycle.
// Backpressure: drain holds o_out_valid until i_out_ready; at most one pop per cycle, 1 kp/cycle with ready high.
module key_buffer_ctrl #(
  parameter int MAX_KP = 100,
  parameter int CNT_W  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  input  logic             i_kp_valid,
  input  logic [7:0]       i_kp_score,
  input  logic [7:0]       i_score_th,
  output logic             o_buf_valid,
  output logic             o_buf_next,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic [CNT_W-1:0] o_kp_count,
  output logic [CNT_W-1:0] o_drop_count,
  output logic             o_busy,
  output logic             o_frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_KP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] kp_cnt_q, kp_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             qualified;
  logic             has_room;

  // A keypoint qualifies on score alone; capacity decides store vs drop.
  assign qualified = i_kp_valid && (i_kp_score >= i_score_th);
  assign has_room  = (kp_cnt_q < MAX_CNT);

  // State and counter registers; counters clear with the buffer on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      kp_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kp_cnt_q   <= kp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next-state, counter updates and buffer/matcher strobes, all derived from registered state.
  always_comb begin
    state_d      = state_q;
    kp_cnt_d     = kp_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    o_buf_valid  = 1'b0;
    o_buf_next   = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Keypoints arriving with frame_start belong to no frame yet and are not stored.
        if (i_frame_start) begin
          state_d    = COLLECT;
          kp_cnt_d   = '0;
          drop_cnt_d = '0;
        end
      end

      COLLECT: begin
        if (qualified && has_room) begin
          o_buf_valid = 1'b1;
          kp_cnt_d    = kp_cnt_q + CNT_ONE;
        end else if (qualified && (drop_cnt_q != CNT_SAT)) begin
          drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
        // kp_cnt_d already includes a keypoint accepted alongside frame_end.
        if (i_frame_end) begin
          state_d = (kp_cnt_d != '0) ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        o_out_valid = (kp_cnt_q != '0);
        o_out_last  = o_out_valid && (kp_cnt_q == CNT_ONE);
        if (o_out_valid && i_out_ready) begin
          o_buf_next = 1'b1;
          kp_cnt_d   = kp_cnt_q - CNT_ONE;
          if (kp_cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end else if (kp_cnt_q == '0) begin
          // Unreachable in normal flow; never strand the FSM in an empty drain.
          state_d = DONE;
        end
      end

      DONE: begin
        o_frame_done = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_kp_count   = kp_cnt_q;
  assign o_drop_count = drop_cnt_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Self-checking bench for key_buffer_ctrl: vector table plus overflow and reset sequences.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Every wait is bounded by a cycle budget.
module tb_key_buffer_ctrl;

  localparam int MAX_KP = 100;
  localparam int CNT_W  = 10;

  logic             clk;
  logic             rst_n;
  logic             frame_start, frame_end, kp_valid, out_ready;
  logic [7:0]       kp_score, score_th;
  logic             buf_valid, buf_next, out_valid, out_last, busy, frame_done;
  logic [CNT_W-1:0] kp_count, drop_count;

  int n_cmp;
  int n_err;

  key_buffer_ctrl #(.MAX_KP(MAX_KP), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_frame_end   (frame_end),
    .i_kp_valid    (kp_valid),
    .i_kp_score    (kp_score),
    .i_score_th    (score_th),
    .o_buf_valid   (buf_valid),
    .o_buf_next    (buf_next),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_last    (out_last),
    .o_kp_count    (kp_count),
    .o_drop_count  (drop_count),
    .o_busy        (busy),
    .o_frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fs, fe, kv;
    logic [7:0] sc, th;
    logic       rdy;
    logic [5:0] flags;  // {buf_valid, buf_next, out_valid, out_last, busy, frame_done}
    int         cnt;
    int         drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fs, logic fe, logic kv, logic [7:0] sc, logic [7:0] th,
                              logic rdy, logic bv, logic nx, logic ov, logic last,
                              logic bz, logic dn, int cnt);
    vec_t v;
    v.fs = fs; v.fe = fe; v.kv = kv; v.sc = sc; v.th = th; v.rdy = rdy;
    v.flags = {bv, nx, ov, last, bz, dn};
    v.cnt = cnt;
    v.drop = 0;
    return v;
  endfunction

  task automatic drive(input logic fs, input logic fe, input logic kv,
                       input logic [7:0] sc, input logic [7:0] th, input logic rdy);
    @(negedge clk);
    frame_start = fs; frame_end = fe; kp_valid = kv;
    kp_score = sc; score_th = th; out_ready = rdy;
    #1;
  endtask

  task automatic check_out(input string name, input logic [5:0] ef, input int ec, input int ed);
    logic [5:0] af;
    af = {buf_valid, buf_next, out_valid, out_last, busy, frame_done};
    n_cmp++;
    if (af !== ef || kp_count !== CNT_W'(ec) || drop_count !== CNT_W'(ed)) begin
      n_err++;
      $display("FAIL %s: got flags(bv,nx,ov,last,busy,done)=%b cnt=%0d drop=%0d, want flags=%b cnt=%0d drop=%0d",
               name, af, kp_count, drop_count, ef, ec, ed);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int model;
    int pops;
    bit seen_done;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    frame_start = 0; frame_end = 0; kp_valid = 0; kp_score = 0; score_th = 0; out_ready = 0;

    // fs fe kv sc th rdy | bv nx ov last busy done | cnt
    // Basic frame, th=20; keypoint with frame_start in IDLE is not stored.
    vecs.push_back(mk(1,0,1, 50,20,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,1, 10,20,0, 0,0,0,0,1,0, 0));
    vecs.push_back(mk(0,0,1, 25,20,0, 1,0,0,0,1,0, 0));
    vecs.push_back(mk(0,0,1, 30,20,0, 1,0,0,0,1,0, 1));
    vecs.push_back(mk(0,0,1,  5,20,0, 0,0,0,0,1,0, 2));
    vecs.push_back(mk(0,0,1, 40,20,0, 1,0,0,0,1,0, 2));
    vecs.push_back(mk(0,1,0,  0,20,0, 0,0,0,0,1,0, 3));
    vecs.push_back(mk(1,0,0,  0,20,1, 0,1,1,0,1,0, 3));  // frame_start in DRAIN ignored
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,0,1,0, 2));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,1,1,0, 1));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,0,0,0,1,1, 0));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,0,0,0,0,0, 0));
    // Four stored (score==th boundary, keypoint with frame_end), then ready 1,0,0,1,1,0,1.
    vecs.push_back(mk(1,0,0,  0,20,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,1, 20,20,0, 1,0,0,0,1,0, 0));
    vecs.push_back(mk(0,0,1, 21,20,0, 1,0,0,0,1,0, 1));
    vecs.push_back(mk(0,0,1,200,20,0, 1,0,0,0,1,0, 2));
    vecs.push_back(mk(0,1,1, 30,20,0, 1,0,0,0,1,0, 3));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,0,1,0, 4));
    vecs.push_back(mk(1,1,1,200,20,0, 0,0,1,0,1,0, 3));  // front-end activity in DRAIN ignored
    vecs.push_back(mk(0,0,0,  0,20,0, 0,0,1,0,1,0, 3));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,0,1,0, 3));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,0,1,0, 2));
    vecs.push_back(mk(0,0,0,  0,20,0, 0,0,1,1,1,0, 1));
    vecs.push_back(mk(0,0,0,  0,20,1, 0,1,1,1,1,0, 1));
    vecs.push_back(mk(0,0,0,  0,20,0, 0,0,0,0,1,1, 0));
    vecs.push_back(mk(0,0,0,  0,20,0, 0,0,0,0,0,0, 0));
    // Empty frame, th=100: COLLECT -> DONE directly.
    vecs.push_back(mk(1,0,0,  0,100,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,1, 99,100,0, 0,0,0,0,1,0, 0));
    vecs.push_back(mk(0,1,0,  0,100,0, 0,0,0,0,1,0, 0));
    vecs.push_back(mk(0,0,0,  0,100,0, 0,0,0,0,1,1, 0));
    // IDLE ignores frame_end, kp_valid and ready.
    vecs.push_back(mk(0,1,1,200,100,1, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,  0,100,0, 0,0,0,0,0,0, 0));

    repeat (2) @(negedge clk);
    #1;
    check_out("reset_state", 6'b000000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fs, vecs[i].fe, vecs[i].kv, vecs[i].sc, vecs[i].th, vecs[i].rdy);
      check_out($sformatf("vec%0d", i), vecs[i].flags, vecs[i].cnt, vecs[i].drop);
    end

    // Overflow: 105 keypoints at th=0 fill to 100 and drop 5.
    drive(1,0,0,0,0,0);
    model = 0;
    for (int i = 0; i < 105; i++) begin
      drive(0,0,1,8'($urandom_range(0,255)),0,0);
      check_bit($sformatf("ovf_bv%0d", i), buf_valid, (model < MAX_KP));
      check_int($sformatf("ovf_cnt%0d", i), int'(kp_count), model);
      if (model < MAX_KP) model++;
    end
    drive(0,0,0,0,0,0);
    check_out("ovf_full", 6'b000010, 100, 5);
    // Keep pushing to saturate the drop counter at all-ones.
    for (int i = 0; i < 1020; i++) begin
      drive(0,0,1,8'd255,0,0);
      if (buf_valid !== 1'b0) check_bit($sformatf("ovf_full_bv%0d", i), buf_valid, 1'b0);
    end
    drive(0,1,0,0,0,0);
    check_out("ovf_drop_sat", 6'b000010, 100, 1023);
    pops = 0;
    seen_done = 0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      drive(0,0,0,0,0,1);
      if (buf_next) pops++;
      if (frame_done) seen_done = 1;
    end
    check_bit("ovf_done_seen", seen_done, 1'b1);
    check_int("ovf_pops", pops, 100);
    drive(1,0,0,0,0,0);
    check_bit("ovf_idle_busy", busy, 1'b0);
    drive(0,0,0,0,0,0);
    check_out("ovf_drop_cleared", 6'b000010, 0, 0);

    // Reset mid-drain with 7 stored.
    for (int i = 0; i < 7; i++) drive(0,0,1,8'd9,0,0);
    drive(0,1,0,0,0,0);
    check_out("rst_pre_fe", 6'b000010, 7, 0);
    drive(0,0,0,0,0,0);
    check_out("rst_drain7", 6'b001010, 7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 6'b000000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0,0,50,0);
    check_out("rst_f2_start", 6'b000000, 0, 0);
    drive(0,0,1,60,50,0);
    check_out("rst_f2_kp0", 6'b100010, 0, 0);
    drive(0,1,1,50,50,0);
    check_out("rst_f2_kp1", 6'b100010, 1, 0);
    drive(0,0,0,0,50,1);
    check_out("rst_f2_pop0", 6'b011010, 2, 0);
    drive(0,0,0,0,50,1);
    check_out("rst_f2_pop1", 6'b011110, 1, 0);
    drive(0,0,0,0,50,0);
    check_out("rst_f2_done", 6'b000011, 0, 0);
    drive(0,0,0,0,50,0);
    check_out("rst_f2_idle", 6'b000000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute watchdog so the run ends even if a sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_buffer_ctrl.md
Name: key_buffer_ctrl

Overview:
Frame-level controller that sequences the keypoint buffer between the ORB front end (FAST score + BRIEF descriptor) and the matcher.
- COLLECT: gates incoming keypoints into the buffer by score threshold and capacity.
- DRAIN: pops stored keypoints to the matcher over a valid/ready handshake.
- Control-only: coordinate, score and descriptor data travel directly front end -> buffer -> matcher; this block drives only buffer strobes and handshakes.

Parameters:
MAX_KP, 100, buffer capacity; maximum keypoints stored per frame (must equal buffer SIZE)
CNT_W, 10, width of occupancy and drop counters

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset
i_frame_start  input  1  one-cycle pulse, start of frame
i_frame_end  input  1  one-cycle pulse, last pixel of frame processed
i_kp_valid  input  1  front end presents a keypoint this cycle
i_kp_score  input  8  score of presented keypoint
i_score_th  input  8  minimum score to store; sampled each cycle
o_buf_valid  output  1  buffer write strobe (buffer i_valid)
o_buf_next  output  1  buffer pop strobe (buffer i_next)
o_out_valid  output  1  buffer head holds a keypoint for matcher
i_out_ready  input  1  matcher accepts head keypoint
o_out_last  output  1  head keypoint is the last of the frame
o_kp_count  output  CNT_W  keypoints currently stored
o_drop_count  output  CNT_W  keypoints dropped this frame (capacity full)
o_busy  output  1  state != IDLE
o_frame_done  output  1  one-cycle pulse, frame fully drained

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; all counters 0; all outputs 0.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - i_frame_start -> COLLECT; clear o_drop_count.
  - A keypoint presented in the same cycle is NOT stored.
  - i_kp_valid, i_frame_end and i_out_ready are ignored.
- COLLECT:
  - Let accept = i_kp_valid && (i_kp_score >= i_score_th) && (o_kp_count < MAX_KP).
  - o_buf_valid = accept (combinational, same cycle as i_kp_valid); o_buf_next = 0.
  - accept -> o_kp_count +1 next cycle.
  - i_kp_valid && score >= threshold && count == MAX_KP -> dropped; o_drop_count +1, saturating at all-ones.
  - Score below threshold -> silently ignored, no counter change.
  - i_frame_end -> DRAIN if count (including a keypoint accepted this cycle) > 0, else DONE.
  - Keypoint and i_frame_end in the same cycle: the keypoint is processed normally.
  - i_frame_start while in COLLECT: ignored.
- DRAIN:
  - o_out_valid = (o_kp_count != 0), registered-state based.
  - o_out_last = (o_kp_count == 1) && o_out_valid.
  - Pop = o_out_valid && i_out_ready -> o_buf_next = 1 (combinational); count -1 next cycle.
  - At most one pop per cycle. The buffer head is updated at the next edge, so back-to-back pops with ready held high are legal: 1 keypoint/cycle.
  - o_out_valid must not drop without a pop.
  - Pop of the last keypoint -> DONE.
  - o_buf_valid = 0. i_kp_valid, i_frame_start and i_frame_end are ignored; the front end must hold off, and keypoints arriving here are not counted.
- DONE: o_frame_done = 1 for exactly one cycle -> IDLE.
- Buffer interaction: o_buf_valid and o_buf_next are never high in the same cycle.
- Count arithmetic: o_kp_count never exceeds MAX_KP, never underflows below 0.
- Reset mid-operation (any state): immediate return to IDLE with zeroed counters. The buffer shares i_rst_n and clears with it.
- Latency:
  - Keypoint -> buffer write: 0 cycles.
  - i_frame_end -> first o_out_valid: 1 cycle.
  - Last pop -> o_frame_done: 1 cycle.

Test Plan:
1. Basic frame:
   - Stimulus: th=20; frame_start; 5 keypoints with scores 10,25,30,5,40; frame_end; ready=1.
   - Required: exactly 3 o_buf_valid pulses; count=3; then 3 consecutive o_buf_next pulses; o_out_last on the 3rd; o_frame_done 1 cycle after the last pop; o_busy low after that.
2. Overflow:
   - Stimulus: th=0; 105 consecutive keypoints.
   - Required: count saturates at 100; o_drop_count=5; o_buf_valid never asserted while count=100; drain yields 100 pops.
3. Backpressure:
   - Stimulus: 4 stored; i_out_ready toggled 1,0,0,1,1,0,1.
   - Required: o_out_valid stays high throughout; o_buf_next only on ready-high cycles; count decrements 4->0 across exactly 4 pops; o_out_last only at count=1.
4. Empty frame:
   - Stimulus: frame_start, no keypoints above threshold, frame_end.
   - Required: COLLECT->DONE directly; o_out_valid never high; o_frame_done pulses 1 cycle after frame_end.
5. Simultaneous events:
   - Stimulus: keypoint (score >= th) in the same cycle as frame_end.
   - Required: keypoint stored; DRAIN count includes it.
   - Stimulus: frame_start with i_kp_valid in IDLE.
   - Required: keypoint not stored.
   - Stimulus: frame_start during DRAIN.
   - Required: ignored.
6. Reset mid-drain:
   - Stimulus: assert i_rst_n low asynchronously, mid-cycle, while count=7.
   - Required: all outputs 0 immediately; state IDLE; a following frame operates normally from count=0.
